// File: rtl/serv_ibus_prefetch_pkg.sv
// rtl/serv_ibus_prefetch_pkg.sv - shared constants and state type for the ibus prefetch buffer
package serv_ibus_prefetch_pkg;

  localparam int TAG_W  = 30;
  localparam int DATA_W = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HIT   = 2'd1;
  localparam logic [1:0] ST_FETCH = 2'd2;
  localparam logic [1:0] ST_PREF  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    HIT   = ST_HIT,
    FETCH = ST_FETCH,
    PREF  = ST_PREF
  } pf_state_t;

endpackage

// File: rtl/serv_ibus_pf_entry.sv
// rtl/serv_ibus_pf_entry.sv - one valid/tag/data entry of the prefetch buffer
module serv_ibus_pf_entry
  import serv_ibus_prefetch_pkg::*;
#(
  parameter string RESET_STRATEGY = "MINI"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_we,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [DATA_W-1:0] i_data,
  input  logic [TAG_W-1:0]  i_cmp_tag,
  output logic              o_match,
  output logic [DATA_W-1:0] o_data
);

  logic              valid;
  logic [TAG_W-1:0]  tag;
  logic [DATA_W-1:0] data;

  // Flush wins over a write landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || i_flush)
      valid <= 1'b0;
    else if (i_we)
      valid <= 1'b1;
  end

  generate
    if (RESET_STRATEGY == "ALL") begin : g_rst_all
      always_ff @(posedge clk) begin
        if (rst) begin
          tag  <= '0;
          data <= '0;
        end else if (i_we && !i_flush) begin
          tag  <= i_tag;
          data <= i_data;
        end
      end
    end else begin : g_rst_mini
      always_ff @(posedge clk) begin
        if (i_we && !i_flush) begin
          tag  <= i_tag;
          data <= i_data;
        end
      end
    end
  endgenerate

  assign o_match = valid && (tag == i_cmp_tag);
  assign o_data  = data;

endmodule

// File: rtl/serv_ibus_prefetch.sv
// rtl/serv_ibus_prefetch.sv - two-entry instruction prefetch buffer in front of a Wishbone ibus
module serv_ibus_prefetch
  import serv_ibus_prefetch_pkg::*;
#(
  parameter bit    PREFETCH       = 1'b1,
  parameter string RESET_STRATEGY = "MINI"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_adr,
  input  logic        i_cyc,
  output logic [31:0] o_rdt,
  output logic        o_ack,
  input  logic        i_flush,
  output logic [31:0] o_wb_adr,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack
);

  pf_state_t         state, state_nxt;
  logic [TAG_W-1:0]  adr_q;
  logic [TAG_W-1:0]  adr_inc;
  logic              lru;
  logic              hit_sel;
  logic              fill_sel;
  logic              kill;
  logic [1:0]        match;
  logic              hit;
  logic              promote;
  logic [DATA_W-1:0] data0, data1;
  logic              wr, wr_sel;
  logic [TAG_W-1:0]  wr_tag;
  logic              unused;

  assign unused  = ^i_adr[1:0];
  assign adr_inc = adr_q + 1'b1;
  assign hit     = |match && !i_flush;
  assign promote = i_cyc && (i_adr[31:2] == adr_inc);

  serv_ibus_pf_entry #(.RESET_STRATEGY(RESET_STRATEGY)) u_entry0 (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (i_flush),
    .i_we      (wr && !wr_sel),
    .i_tag     (wr_tag),
    .i_data    (i_wb_rdt),
    .i_cmp_tag (i_adr[31:2]),
    .o_match   (match[0]),
    .o_data    (data0)
  );

  serv_ibus_pf_entry #(.RESET_STRATEGY(RESET_STRATEGY)) u_entry1 (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (i_flush),
    .i_we      (wr && wr_sel),
    .i_tag     (wr_tag),
    .i_data    (i_wb_rdt),
    .i_cmp_tag (i_adr[31:2]),
    .o_match   (match[1]),
    .o_data    (data1)
  );

  always_comb begin
    state_nxt = state;
    o_ack     = 1'b0;
    o_rdt     = '0;
    o_wb_cyc  = 1'b0;
    o_wb_adr  = '0;
    wr        = 1'b0;
    wr_sel    = 1'b0;
    wr_tag    = adr_q;
    case (state)
      IDLE: begin
        if (i_cyc)
          state_nxt = hit ? HIT : FETCH;
      end
      HIT: begin
        o_ack     = 1'b1;
        o_rdt     = hit_sel ? data1 : data0;
        state_nxt = IDLE;
      end
      FETCH: begin
        o_wb_cyc = 1'b1;
        o_wb_adr = {adr_q, 2'b00};
        if (i_wb_ack) begin
          o_ack     = 1'b1;
          o_rdt     = i_wb_rdt;
          wr        = !kill;
          wr_sel    = lru;
          state_nxt = PREFETCH ? PREF : IDLE;
        end
      end
      PREF: begin
        o_wb_cyc = 1'b1;
        o_wb_adr = {adr_inc, 2'b00};
        wr_tag   = adr_inc;
        if (i_wb_ack) begin
          // A waiting request for the prefetched word is answered straight from the bus.
          o_ack     = promote;
          o_rdt     = promote ? i_wb_rdt : '0;
          wr        = !kill;
          wr_sel    = fill_sel;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // kill remembers a flush seen earlier in the bus cycle so the returning word is not cached.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lru      <= 1'b0;
      kill     <= 1'b0;
      hit_sel  <= 1'b0;
      fill_sel <= 1'b0;
      adr_q    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (i_cyc) begin
            kill <= 1'b0;
            if (hit)
              hit_sel <= match[1];
            else
              adr_q <= i_adr[31:2];
          end
        end
        HIT: lru <= ~hit_sel;
        FETCH: begin
          if (i_wb_ack) begin
            lru      <= ~lru;
            fill_sel <= ~lru;
            kill     <= 1'b0;
          end else if (i_flush) begin
            kill <= 1'b1;
          end
        end
        PREF: begin
          if (i_wb_ack)
            lru <= ~fill_sel;
          else if (i_flush)
            kill <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serv_ibus_prefetch.sv
// tb/tb_serv_ibus_prefetch.sv - directed self-checking bench for serv_ibus_prefetch
module tb_serv_ibus_prefetch;

  localparam int MEM_DLY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_adr = '0;
  logic        i_cyc = 1'b0;
  logic [31:0] o_rdt;
  logic        o_ack;
  logic        i_flush = 1'b0;
  logic [31:0] o_wb_adr;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;

  logic        mem_en = 1'b1;
  logic        auto_ack = 1'b0;
  logic [31:0] auto_rdt = '0;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdt = '0;
  int          wb_cnt = 0;
  int          dly_cnt = 0;

  int total = 0;
  int bad = 0;

  assign i_wb_ack = mem_en ? auto_ack : man_ack;
  assign i_wb_rdt = mem_en ? auto_rdt : man_rdt;

  serv_ibus_prefetch #(.PREFETCH(1'b1), .RESET_STRATEGY("MINI")) dut (
    .clk      (clk),
    .rst      (rst),
    .i_adr    (i_adr),
    .i_cyc    (i_cyc),
    .o_rdt    (o_rdt),
    .o_ack    (o_ack),
    .i_flush  (i_flush),
    .o_wb_adr (o_wb_adr),
    .o_wb_cyc (o_wb_cyc),
    .i_wb_rdt (i_wb_rdt),
    .i_wb_ack (i_wb_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w == 32'h100) ? 32'h0000_0013 : ((w ^ 32'h5a5a_0000) + 32'h11);
  endfunction

  // Memory model: acks MEM_DLY+1 cycles into each bus cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_en && o_wb_cyc) begin
        if (dly_cnt == MEM_DLY) begin
          auto_ack = 1'b1;
          auto_rdt = mem_word(o_wb_adr);
          wb_cnt++;
          dly_cnt = 0;
        end else begin
          auto_ack = 1'b0;
          auto_rdt = '0;
          dly_cnt++;
        end
      end else begin
        auto_ack = 1'b0;
        auto_rdt = '0;
        dly_cnt = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && o_wb_cyc; k++) @(negedge clk);
    chk("idle_timeout", {31'd0, o_wb_cyc}, 32'd0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_cyc = 1'b0;
    i_flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] adr, input int flush_at,
                        output logic [31:0] rdt, output int lat, output bit saw_wb);
    bit got;
    wait_idle();
    i_cyc = 1'b1;
    i_adr = adr;
    i_flush = (flush_at == 0);
    lat = 0;
    saw_wb = 1'b0;
    got = 1'b0;
    rdt = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lat++;
      if (o_wb_cyc) saw_wb = 1'b1;
      if (o_ack) begin
        rdt = o_rdt;
        got = 1'b1;
        break;
      end
      i_flush = (lat == flush_at);
    end
    i_cyc = 1'b0;
    i_flush = 1'b0;
    chk("req_timeout", {31'd0, got}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] adr;
    bit          hit;
  } vec_t;

  initial begin
    vec_t        vecs[11];
    logic [31:0] rdt, rdt2, ack_adr;
    int          lat, acks, wb0;
    bit          saw_wb, saw_pref, pref_ack;

    vecs[0]  = '{32'h0000_0104, 1'b1};
    vecs[1]  = '{32'h0000_0103, 1'b1};
    vecs[2]  = '{32'h0000_0108, 1'b0};
    vecs[3]  = '{32'h0000_010C, 1'b1};
    vecs[4]  = '{32'h0000_0108, 1'b1};
    vecs[5]  = '{32'h0000_0100, 1'b0};
    vecs[6]  = '{32'h0000_0104, 1'b1};
    vecs[7]  = '{32'h0000_0100, 1'b1};
    vecs[8]  = '{32'hFFFF_FFFC, 1'b0};
    vecs[9]  = '{32'h0000_0000, 1'b1};
    vecs[10] = '{32'hFFFF_FFFE, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, o_ack}, 32'd0);
    chk("rst_cyc", {31'd0, o_wb_cyc}, 32'd0);
    chk("rst_rdt", o_rdt, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss followed by the speculative fetch of the next word.
    i_cyc = 1'b1;
    i_adr = 32'h100;
    @(negedge clk);
    chk("cold_cyc", {31'd0, o_wb_cyc}, 32'd1);
    chk("cold_adr", o_wb_adr, 32'h100);
    chk("cold_noack", {31'd0, o_ack}, 32'd0);
    @(negedge clk);
    chk("cold_noack2", {31'd0, o_ack}, 32'd0);
    @(negedge clk);
    chk("cold_ack", {31'd0, o_ack}, 32'd1);
    chk("cold_rdt", o_rdt, 32'h0000_0013);
    i_cyc = 1'b0;
    @(negedge clk);
    chk("pref_cyc", {31'd0, o_wb_cyc}, 32'd1);
    chk("pref_adr", o_wb_adr, 32'h104);
    pref_ack = 1'b0;
    for (int k = 0; k < 20 && o_wb_cyc; k++) begin
      if (o_ack) pref_ack = 1'b1;
      @(negedge clk);
    end
    chk("pref_no_ack", {31'd0, pref_ack}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].adr, -1, rdt, lat, saw_wb);
      chk($sformatf("vec%0d_rdt", i), rdt, mem_word(vecs[i].adr));
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].hit ? 32'd1 : 32'd3);
      chk($sformatf("vec%0d_wb", i), {31'd0, saw_wb}, {31'd0, !vecs[i].hit});
    end

    // Misaligned pair: second word comes from the promoted prefetch.
    do_reset();
    wait_idle();
    wb0 = wb_cnt;
    acks = 0;
    rdt = '0;
    rdt2 = '0;
    i_cyc = 1'b1;
    i_adr = 32'h102;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_ack) begin
        acks++;
        if (acks == 1) begin
          rdt = o_rdt;
          i_adr = 32'h106;
        end else begin
          rdt2 = o_rdt;
          i_cyc = 1'b0;
          break;
        end
      end
    end
    i_cyc = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("mis_acks", acks, 32'd2);
    chk("mis_wbcnt", wb_cnt - wb0, 32'd2);
    chk("mis_rdt0", rdt, mem_word(32'h100));
    chk("mis_rdt1", rdt2, mem_word(32'h104));

    // Unrelated request while the prefetch is outstanding waits for it.
    do_reset();
    do_req(32'h100, -1, rdt, lat, saw_wb);
    i_cyc = 1'b1;
    i_adr = 32'h200;
    saw_pref = 1'b0;
    ack_adr = '0;
    rdt = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_wb_cyc && o_wb_adr == 32'h104) saw_pref = 1'b1;
      if (o_ack) begin
        ack_adr = o_wb_adr;
        rdt = o_rdt;
        break;
      end
    end
    i_cyc = 1'b0;
    chk("ns_saw_pref", {31'd0, saw_pref}, 32'd1);
    chk("ns_ack_adr", ack_adr, 32'h200);
    chk("ns_rdt", rdt, mem_word(32'h200));
    do_req(32'h200, -1, rdt, lat, saw_wb);
    chk("ns_hit200", lat, 32'd1);
    do_req(32'h100, -1, rdt, lat, saw_wb);
    chk("ns_evict100", {31'd0, saw_wb}, 32'd1);

    // Flush while idle, during the prefetch, during a demand fetch, and with a request.
    do_reset();
    do_req(32'h100, -1, rdt, lat, saw_wb);
    wait_idle();
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    do_req(32'h104, -1, rdt, lat, saw_wb);
    chk("fl_idle_miss", {31'd0, saw_wb}, 32'd1);
    do_req(32'h300, -1, rdt, lat, saw_wb);
    @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    do_req(32'h304, -1, rdt, lat, saw_wb);
    chk("fl_pref_miss", {31'd0, saw_wb}, 32'd1);
    do_req(32'h500, 1, rdt, lat, saw_wb);
    chk("fl_fetch_rdt", rdt, mem_word(32'h500));
    do_req(32'h504, -1, rdt, lat, saw_wb);
    chk("fl_fetch_pref_hit", lat, 32'd1);
    do_req(32'h500, -1, rdt, lat, saw_wb);
    chk("fl_fetch_nowrite", {31'd0, saw_wb}, 32'd1);
    do_req(32'h504, 0, rdt, lat, saw_wb);
    chk("fl_req_same_cycle", {31'd0, saw_wb}, 32'd1);
    chk("fl_req_rdt", rdt, mem_word(32'h504));

    // Reset in the middle of a fetch, then a stray ack.
    wait_idle();
    mem_en = 1'b0;
    i_cyc = 1'b1;
    i_adr = 32'h400;
    @(negedge clk);
    chk("rf_cyc", {31'd0, o_wb_cyc}, 32'd1);
    chk("rf_adr", o_wb_adr, 32'h400);
    rst = 1'b1;
    i_cyc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rf_cyc_drop", {31'd0, o_wb_cyc}, 32'd0);
    chk("rf_ack_drop", {31'd0, o_ack}, 32'd0);
    man_ack = 1'b1;
    man_rdt = 32'hDEAD_BEEF;
    #1;
    chk("rf_stray_ack", {31'd0, o_ack}, 32'd0);
    chk("rf_stray_rdt", o_rdt, 32'd0);
    @(negedge clk);
    man_ack = 1'b0;
    man_rdt = '0;
    mem_en = 1'b1;
    do_req(32'h400, -1, rdt, lat, saw_wb);
    chk("rf_miss", {31'd0, saw_wb}, 32'd1);
    chk("rf_rdt", rdt, mem_word(32'h400));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
